// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular exponentiation engine and its multiplier.
package mod_exp_pkg;

  // Sequencer states of the square-and-multiply engine.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    SQR  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Operand width shared with the GCD unit downstream.
  localparam int MODEXP_WIDTH = 32;

  // Width of a counter that must hold the value WIDTH.
  function automatic int mulCntWidth(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int MUL_CNT_W = mulCntWidth(MODEXP_WIDTH);

endpackage

// File: rtl/mod_mul.sv
// Bit-serial interleaved modular multiplier: p = x*y mod n in exactly WIDTH cycles.
// The first iteration is performed on the start edge from the live operands, so
// done pulses in the cycle right after the WIDTH-th iteration edge.
module mod_mul
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = MODEXP_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  logic [WIDTH-1:0] xR;
  logic [WIDTH-1:0] nR;
  logic [WIDTH-1:0] yShift;
  logic [WIDTH-1:0] pR;
  logic [CNT_W-1:0] cnt;
  logic             active;
  logic             doneR;

  // One shift-add-reduce step. With acc < m and addend < m the sum is below 3m,
  // so two conditional subtractions restore acc < m; two guard bits avoid overflow.
  function automatic logic [WIDTH-1:0] stepMod(input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] addend,
                                               input logic [WIDTH-1:0] m,
                                               input logic             bitIn);
    logic [WIDTH+1:0] t;
    t = {1'b0, acc, 1'b0} + (bitIn ? {2'b00, addend} : '0);
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[WIDTH-1:0];
  endfunction

  // Iteration engine: latch operands on start, then scan y MSB-first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xR     <= '0;
      nR     <= '0;
      yShift <= '0;
      pR     <= '0;
      cnt    <= '0;
      active <= 1'b0;
      doneR  <= 1'b0;
    end else begin
      doneR <= 1'b0;
      if (start) begin
        pR     <= stepMod('0, x, n, y[WIDTH-1]);
        xR     <= x;
        nR     <= n;
        yShift <= {y[WIDTH-2:0], 1'b0};
        cnt    <= CNT_W'(1);
        active <= 1'b1;
      end else if (active) begin
        pR     <= stepMod(pR, xR, nR, yShift[WIDTH-1]);
        yShift <= {yShift[WIDTH-2:0], 1'b0};
        cnt    <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          active <= 1'b0;
          doneR  <= 1'b1;
        end
      end
    end
  end

  assign done = doneR;
  assign p    = pR;

endmodule

// File: rtl/mod_exp.sv
// Modular exponentiation engine: result = base^exponent mod modulus, plus
// result_minus_one for the GCD stage. Right-to-left square-and-multiply driving
// one shared bit-serial modular multiplier; results leave on valid/ready.
module mod_exp
  import mod_exp_pkg::*;
#(
  parameter int WIDTH     = MODEXP_WIDTH,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic [WIDTH-1:0]     result_minus_one,
  output logic                 err
);

  localparam int CNT_W = mulCntWidth(WIDTH);

  state_t state;
  state_t stateN;

  // Operands captured at start; the ports are don't-care afterwards.
  logic [WIDTH-1:0]     baseR;
  logic [EXP_WIDTH-1:0] expR;
  logic [WIDTH-1:0]     modR;

  // Working registers: accumulator, running square, exponent bits not yet consumed.
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     b;
  logic [EXP_WIDTH-1:0] e;
  logic [WIDTH-1:0]     accN;
  logic [WIDTH-1:0]     bN;
  logic [EXP_WIDTH-1:0] eN;

  logic                 finish;
  logic [WIDTH-1:0]     finRes;
  logic                 finErr;

  logic                 mulStart;
  logic                 mulDone;
  logic [WIDTH-1:0]     mulX;
  logic [WIDTH-1:0]     mulY;
  logic [WIDTH-1:0]     mulP;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateN;
  end

  // Next-state and datapath decisions. Each operation is launched on the same
  // edge that enters MUL/SQR, so every multiply occupies exactly WIDTH cycles.
  always_comb begin
    stateN   = state;
    accN     = acc;
    bN       = b;
    eN       = e;
    mulStart = 1'b0;
    finish   = 1'b0;
    finRes   = '0;
    finErr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) stateN = LOAD;
      end
      LOAD: begin
        accN = WIDTH'(1);
        bN   = baseR;
        eN   = expR;
        if (modR == '0 || baseR >= modR) begin
          finish = 1'b1;
          finErr = 1'b1;
          stateN = DONE;
        end else if (modR == WIDTH'(1)) begin
          finish = 1'b1;
          stateN = DONE;
        end else if (expR == '0) begin
          finish = 1'b1;
          finRes = WIDTH'(1);
          stateN = DONE;
        end else if (expR[0]) begin
          mulStart = 1'b1;
          stateN   = MUL;
        end else begin
          // Bit 0 is clear: it needs no multiply, so it is consumed here.
          eN       = expR >> 1;
          mulStart = 1'b1;
          stateN   = SQR;
        end
      end
      MUL: begin
        if (mulDone) begin
          accN = mulP;
          eN   = e >> 1;
          if (eN == '0) begin
            finish = 1'b1;
            finRes = mulP;
            stateN = DONE;
          end else begin
            mulStart = 1'b1;
            stateN   = SQR;
          end
        end
      end
      SQR: begin
        if (mulDone) begin
          bN       = mulP;
          mulStart = 1'b1;
          if (e[0]) begin
            stateN = MUL;
          end else begin
            // e is non-zero with bit 0 clear, so the shifted value stays non-zero.
            eN = e >> 1;
          end
        end
      end
      DONE: begin
        if (out_valid && out_ready) stateN = IDLE;
      end
      default: stateN = IDLE;
    endcase
  end

  // Multiplier operands follow the values the working registers take this edge.
  assign mulX = (stateN == MUL) ? accN : bN;
  assign mulY = bN;

  mod_mul #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mod_mul (
    .clk  (clk),
    .reset(reset),
    .start(mulStart),
    .x    (mulX),
    .y    (mulY),
    .n    (modR),
    .done (mulDone),
    .p    (mulP)
  );

  // Operand capture, working registers and the registered output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baseR            <= '0;
      expR             <= '0;
      modR             <= '0;
      acc              <= '0;
      b                <= '0;
      e                <= '0;
      busy             <= 1'b0;
      out_valid        <= 1'b0;
      result           <= '0;
      result_minus_one <= '0;
      err              <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        baseR <= base;
        expR  <= exponent;
        modR  <= modulus;
        busy  <= 1'b1;
      end
      acc <= accN;
      b   <= bN;
      e   <= eN;
      if (finish) begin
        result           <= finRes;
        result_minus_one <= (finRes == '0) ? modR - WIDTH'(1) : finRes - WIDTH'(1);
        err              <= finErr;
        out_valid        <= 1'b1;
      end else if (state == DONE && out_valid && out_ready) begin
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end
    end
  end

endmodule
